// File: rtl/decode_pkg.sv
// Shared constants and types for the decode byte queue.
package decode_pkg;
  localparam int DECODE_WINDOW_BYTES = 8;
  localparam int FETCH_PACKET_BYTES  = 4;
  localparam int DEFAULT_DEPTH       = 16;

  typedef logic [7:0] byte_t;
endpackage

// File: rtl/decode_window_rotator.sv
// Selects the 8 oldest queued bytes from the circular buffer.
module decode_window_rotator
  import decode_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  byte_t            mem_i    [DEPTH],
  input  logic [PTR_W-1:0] rd_ptr_i,
  input  logic [PTR_W:0]   count_i,
  output byte_t            win_o    [DECODE_WINDOW_BYTES],
  output logic [3:0]       wbytes_o
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx [DECODE_WINDOW_BYTES];

  assign wbytes_o = (count_i > CNT_W'(DECODE_WINDOW_BYTES))
                  ? 4'(DECODE_WINDOW_BYTES)
                  : 4'(count_i);

  // Pointer arithmetic truncates to PTR_W, so the window wraps for free.
  for (genvar k = 0; k < DECODE_WINDOW_BYTES; k++) begin : g_win
    assign idx[k]   = rd_ptr_i + PTR_W'(k);
    assign win_o[k] = (4'(k) < wbytes_o) ? mem_i[idx[k]] : 8'h00;
  end

endmodule

// File: rtl/decode_byte_queue.sv
// Instruction byte queue: packet push, aligned window, consume retire.
module decode_byte_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_fetch_valid,
  input  logic [2:0]       i_fetch_bytes,
  input  byte_t            i_fetch_data [0:3],
  output logic             o_fetch_ready,
  output byte_t            o_window     [0:7],
  output logic [3:0]       o_window_bytes,
  input  logic             i_consume_valid,
  input  logic [3:0]       i_consume_bytes,
  output logic [PTR_W:0]   o_count,
  output logic             o_error
);

  localparam int CNT_W = PTR_W + 1;

  byte_t            mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             err_q, err_d;

  logic push_legal, push_take, push_bad;
  logic cons_ok, cons_bad;

  assign o_fetch_ready = count_q <= CNT_W'(DEPTH - FETCH_PACKET_BYTES);

  assign push_legal = (i_fetch_bytes != 3'd0)
                   && (i_fetch_bytes <= 3'(FETCH_PACKET_BYTES));
  assign push_take  = i_fetch_valid && o_fetch_ready && push_legal;
  assign push_bad   = i_fetch_valid && o_fetch_ready && !push_legal;

  // Window never exceeds 8, so this also rejects counts above 8.
  assign cons_ok  = i_consume_valid && (i_consume_bytes <= o_window_bytes);
  assign cons_bad = i_consume_valid && !cons_ok;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    err_d   = 1'b0;
    if (i_flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push_take) begin
        wr_d = wr_q + PTR_W'(i_fetch_bytes);
      end
      if (cons_ok) begin
        rd_d = rd_q + PTR_W'(i_consume_bytes);
      end
      count_d = count_q
              + (push_take ? CNT_W'(i_fetch_bytes) : '0)
              - (cons_ok ? CNT_W'(i_consume_bytes) : '0);
      err_d   = push_bad || cons_bad;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately unreset; the pointers define validity.
  always_ff @(posedge i_clock) begin
    for (int k = 0; k < FETCH_PACKET_BYTES; k++) begin
      if (!i_reset && !i_flush && push_take
          && (3'(k) < i_fetch_bytes)) begin
        mem_q[wr_q + PTR_W'(k)] <= i_fetch_data[k];
      end
    end
  end

  decode_window_rotator #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rot (
    .mem_i    (mem_q),
    .rd_ptr_i (rd_q),
    .count_i  (count_q),
    .win_o    (o_window),
    .wbytes_o (o_window_bytes)
  );

  assign o_count = count_q;
  assign o_error = err_q;

endmodule

// File: tb/tb_decode_byte_queue.sv
// Directed bench for decode_byte_queue with hand-computed expectations.
module tb_decode_byte_queue;
  import decode_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       fv;
  logic [2:0] fb;
  byte_t      fd  [0:3];
  logic       rdy;
  byte_t      win [0:7];
  logic [3:0] wb;
  logic       cv;
  logic [3:0] cb;
  logic [4:0] cnt;
  logic       err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_byte_queue dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_flush         (flush),
    .i_fetch_valid   (fv),
    .i_fetch_bytes   (fb),
    .i_fetch_data    (fd),
    .o_fetch_ready   (rdy),
    .o_window        (win),
    .o_window_bytes  (wb),
    .i_consume_valid (cv),
    .i_consume_bytes (cb),
    .o_count         (cnt),
    .o_error         (err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; flush = 0; fv = 0; fb = 0; cv = 0; cb = 0;
    for (int i = 0; i < 4; i++) fd[i] = 8'h00;
  endtask

  task automatic set_push(input logic [2:0] n, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3);
    fv = 1; fb = n;
    fd[0] = b0; fd[1] = b1; fd[2] = b2; fd[3] = b3;
  endtask

  task automatic push(input logic [2:0] n, input logic [7:0] b0,
                      input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3);
    set_push(n, b0, b1, b2, b3);
    tick();
    idle();
  endtask

  task automatic consume(input logic [3:0] n);
    cv = 1; cb = n;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    tick();
    rst = 0;
    chk("rst_count", cnt, 0);
    chk("rst_wbytes", wb, 0);
    chk("rst_ready", rdy, 1);
    chk("rst_err", err, 0);
    chk("rst_win0", win[0], 8'h00);

    push(4, 8'h8B, 8'h45, 8'h08, 8'h90);
    chk("p1_w0", win[0], 8'h8B);
    chk("p1_w1", win[1], 8'h45);
    chk("p1_w2", win[2], 8'h08);
    chk("p1_w3", win[3], 8'h90);
    chk("p1_w4", win[4], 8'h00);
    chk("p1_wbytes", wb, 4);
    chk("p1_count", cnt, 4);
    chk("p1_ready", rdy, 1);

    push(4, 8'h10, 8'h11, 8'h12, 8'h13);
    push(4, 8'h14, 8'h15, 8'h16, 8'h17);
    chk("p3_ready", rdy, 1);
    push(4, 8'h18, 8'h19, 8'h1A, 8'h1B);
    chk("full_ready", rdy, 0);
    chk("full_count", cnt, 16);
    chk("full_wbytes", wb, 8);
    chk("full_w4", win[4], 8'h10);
    chk("full_w7", win[7], 8'h13);
    push(4, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    chk("held_count", cnt, 16);
    chk("held_err", err, 0);
    chk("held_w0", win[0], 8'h8B);

    consume(8);
    chk("c8_count", cnt, 8);
    chk("c8_w0", win[0], 8'h14);
    consume(6);
    chk("c6_count", cnt, 2);
    push(4, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    push(4, 8'hA4, 8'hA5, 8'hA6, 8'hA7);
    push(2, 8'hA8, 8'hA9, 8'hFF, 8'hFF);
    chk("wrap_count", cnt, 12);
    chk("wrap_w0", win[0], 8'h1A);
    chk("wrap_w1", win[1], 8'h1B);
    chk("wrap_w2", win[2], 8'hA0);
    chk("wrap_w7", win[7], 8'hA5);
    consume(6);
    chk("wc6_count", cnt, 6);
    chk("wc6_wbytes", wb, 6);
    chk("wc6_w0", win[0], 8'hA4);
    chk("wc6_w5", win[5], 8'hA9);
    chk("wc6_w6", win[6], 8'h00);

    consume(1);
    chk("c1_count", cnt, 5);
    set_push(4, 8'hB0, 8'hB1, 8'hB2, 8'hB3);
    cv = 1; cb = 3;
    tick();
    idle();
    chk("pc_count", cnt, 6);
    chk("pc_w0", win[0], 8'hA8);
    chk("pc_w2", win[2], 8'hB0);
    chk("pc_w5", win[5], 8'hB3);

    consume(1);
    chk("pre_bad_wbytes", wb, 5);
    consume(7);
    chk("bad_c_err", err, 1);
    chk("bad_c_count", cnt, 5);
    tick();
    chk("bad_c_pulse", err, 0);
    push(0, 8'h55, 8'h55, 8'h55, 8'h55);
    chk("bad_p_err", err, 1);
    chk("bad_p_count", cnt, 5);
    chk("bad_p_w0", win[0], 8'hA9);
    tick();
    chk("bad_p_pulse", err, 0);
    consume(9);
    chk("c9_err", err, 1);
    set_push(5, 8'h66, 8'h66, 8'h66, 8'h66);
    cv = 1; cb = 8;
    tick();
    idle();
    chk("both_err", err, 1);
    chk("both_count", cnt, 5);
    tick();
    chk("both_pulse", err, 0);

    push(4, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
    push(1, 8'hC4, 8'h00, 8'h00, 8'h00);
    chk("pre_fl_count", cnt, 10);
    flush = 1;
    set_push(4, 8'hDD, 8'hDD, 8'hDD, 8'hDD);
    cv = 1; cb = 2;
    tick();
    idle();
    chk("fl_count", cnt, 0);
    chk("fl_wbytes", wb, 0);
    chk("fl_w0", win[0], 8'h00);
    chk("fl_ready", rdy, 1);
    chk("fl_err", err, 0);
    push(1, 8'hD0, 8'h00, 8'h00, 8'h00);
    chk("afl_w0", win[0], 8'hD0);
    chk("afl_count", cnt, 1);

    push(4, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
    rst = 1;
    set_push(4, 8'hE4, 8'hE5, 8'hE6, 8'hE7);
    tick();
    idle();
    chk("mr_count", cnt, 0);
    chk("mr_wbytes", wb, 0);
    chk("mr_w0", win[0], 8'h00);
    chk("mr_ready", rdy, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
